axi_burst_master: RTL and testbench
===================================

# axi_burst_master

Parametrised AXI-style bus master with independent read and write engines: it converts a single-cycle command into a full address/data/response burst on the bus. It generalises the existing fixed 8-bit, 16-beat master:
- address, data, ID and length widths are parameters;
- reads are buffered into a burst-wide vector;
- WLAST is exact;
- there is burst-length and response error checking.

It sits between a local command source (testbench or controller) and the slave fabric.

## Interface
Parameters:
- ADDR_W, 8, address width
- DATA_W, 8, beat data width
- ID_W, 4, transaction ID width
- LEN_W, 4, burst length field width; MAX_BEATS = 2**LEN_W (derived, not overridable)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rd_req  in  1  start read burst (sampled only in R_IDLE)
- rd_addr, rd_len, rd_id  in  ADDR_W, LEN_W, ID_W  read command; rd_len = beats-1
- rd_busy  out  1  read engine not idle
- rd_done  out  1  one-cycle pulse at read completion
- rd_err  out  1  read error, valid with rd_done, held until next rd_req accepted
- rd_data  out  MAX_BEATS*DATA_W  beat k at [k*DATA_W +: DATA_W]
- ARVALID out 1, ARREADY in 1, ARADDR out ADDR_W, ARLEN out LEN_W, ARID out ID_W
- RVALID in 1, RREADY out 1, RDATA in DATA_W, RRESP in 2, RLAST in 1
- wr_req  in  1  start write burst (sampled only in W_IDLE)
- wr_addr, wr_len, wr_id  in  ADDR_W, LEN_W, ID_W  write command
- wr_data  in  MAX_BEATS*DATA_W  captured at acceptance
- wr_busy out 1, wr_done out 1 (pulse), wr_resp out 2 (BRESP captured)
- AWVALID out 1, AWREADY in 1, AWADDR out ADDR_W, AWLEN out LEN_W, AWID out ID_W
- WVALID out 1, WREADY in 1, WDATA out DATA_W, WLAST out 1
- BVALID in 1, BREADY out 1, BRESP in 2

## Operation
- **Engines.** The read and write engines are fully independent and may run concurrently. Both engines drive only registered outputs.
- **Reset.** On rst low, all outputs are 0, both FSMs go to IDLE and the beat counters clear. This holds for reset mid-burst too: the bus is abandoned and no done pulse is produced.
- **Read FSM:**
  - R_IDLE: on rd_req, latch addr/len/id, clear rd_data and rd_err, go to R_ADDR.
  - R_ADDR: ARVALID=1 with the latched fields, held stable until ARREADY. On the handshake, go to R_DATA.
  - R_DATA: RREADY=1. Each RVALID beat with beat_cnt<=len stores RDATA at index beat_cnt. Then beat_cnt increments (LEN_W+1 bits, no wrap).
  - R_DATA errors: RRESP!=0 on any beat sets rd_err (sticky). A beat arriving with beat_cnt>len is discarded and sets rd_err.
  - R_DATA exit: on the RLAST beat, set rd_err if beat_cnt!=len (early or late RLAST), then go to R_IDLE with rd_done=1 for one cycle.
- **Write FSM:**
  - W_IDLE: on wr_req, latch command and wr_data, go to W_ADDR.
  - W_ADDR: AWVALID=1 until AWREADY. WVALID stays 0 (W beats start only after AW is accepted). On the handshake, go to W_DATA.
  - W_DATA: WVALID=1, WDATA=slice[beat_cnt], WLAST=(beat_cnt==len). On a WREADY handshake, advance beat_cnt and the slice. After the WLAST handshake, WVALID=0 and go to W_RESP.
  - W_RESP: BREADY=1. On BVALID, capture BRESP into wr_resp, go to W_IDLE, pulse wr_done.
- rd_busy/wr_busy = FSM not in IDLE.
- A request arriving while its engine is busy is ignored (not queued).
- len=0 means one beat: WLAST is set on the first beat, and a single RLAST beat completes without error.

## Timing
- rd_req/wr_req sampled high at edge N → ARVALID/AWVALID high after edge N, busy high after edge N.
- AR/AW handshake at edge N → RREADY or WVALID high after edge N (no bubble).
- Write burst of L+1 beats with WREADY held high: L+1 cycles of WVALID, then BREADY the following cycle.
- Best-case write: req → wr_done = 1 (AW) + L+1 (W) + 1 (B) cycles after acceptance.
- Best-case read: req → rd_done = 1 (AR) + L+1 (R) cycles after acceptance.
- The done pulse occurs in the first cycle back in IDLE; a req sampled in that same cycle is accepted.
- VALID, once asserted, never drops and payload never changes until its handshake.

## Test plan
- **Reset mid-burst:** assert rst low during W_DATA beat 2 of len=5 → all outputs 0 immediately; the next wr_req starts from beat 0 with no wr_done pulse.
- **Read, len=3, no stalls:** RDATA 0x11,0x22,0x33,0x44 with RLAST on the 4th beat → rd_data[31:0]=0x44332211, rd_err=0, rd_done pulse 5 cycles after acceptance.
- **Write, len=2, WREADY stalled:** wr_data low bytes 0xA1,0xB2,0xC3; WREADY low for 2 cycles on beat 1 → WDATA holds 0xB2 while stalled, WLAST only with 0xC3; BRESP=2 → wr_resp=2.
- **Read error cases:** RLAST on beat 1 of len=3 → rd_err=1 and done. Separately, RRESP=2 on beat 0 → rd_err=1 after RLAST.
- **Concurrent read/write:** issue len=15 read and len=15 write in the same cycle with ARREADY/AWREADY delayed 3 cycles → both complete correctly. A wr_req pulsed mid-burst is ignored.
- **len=0 write, AWREADY held low 4 cycles:** AWVALID stable for 5 cycles, WVALID stays 0 until AW is accepted, then exactly one beat with WLAST=1.

Source files
------------

// File: rtl/axi_burst_master.sv
// AXI-style burst master with independent read and write engines.
// Each engine turns a single-cycle command into a full address/data/response
// burst. All outputs are registered.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   rd_req/rd_addr/rd_len/rd_id   read command (rd_len = beats-1)
//   rd_busy/rd_done/rd_err        read status (done pulses, err valid with done)
//   rd_data                       read burst buffer, beat k at [k*DATA_W +: DATA_W]
//   AR*/R*                        read address and read data channels
//   wr_req/wr_addr/wr_len/wr_id   write command
//   wr_data                       write burst payload, captured at acceptance
//   wr_busy/wr_done/wr_resp       write status (done pulses, BRESP captured)
//   AW*/W*/B*                     write address, write data and response channels
module axi_burst_master #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  // read command / status
  input  logic                             rd_req,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic [LEN_W-1:0]                 rd_len,
  input  logic [ID_W-1:0]                  rd_id,
  output logic                             rd_busy,
  output logic                             rd_done,
  output logic                             rd_err,
  output logic [(2**LEN_W)*DATA_W-1:0]     rd_data,
  // read address channel
  output logic                             ARVALID,
  input  logic                             ARREADY,
  output logic [ADDR_W-1:0]                ARADDR,
  output logic [LEN_W-1:0]                 ARLEN,
  output logic [ID_W-1:0]                  ARID,
  // read data channel
  input  logic                             RVALID,
  output logic                             RREADY,
  input  logic [DATA_W-1:0]                RDATA,
  input  logic [1:0]                       RRESP,
  input  logic                             RLAST,
  // write command / status
  input  logic                             wr_req,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [LEN_W-1:0]                 wr_len,
  input  logic [ID_W-1:0]                  wr_id,
  input  logic [(2**LEN_W)*DATA_W-1:0]     wr_data,
  output logic                             wr_busy,
  output logic                             wr_done,
  output logic [1:0]                       wr_resp,
  // write address channel
  output logic                             AWVALID,
  input  logic                             AWREADY,
  output logic [ADDR_W-1:0]                AWADDR,
  output logic [LEN_W-1:0]                 AWLEN,
  output logic [ID_W-1:0]                  AWID,
  // write data channel
  output logic                             WVALID,
  input  logic                             WREADY,
  output logic [DATA_W-1:0]                WDATA,
  output logic                             WLAST,
  // write response channel
  input  logic                             BVALID,
  output logic                             BREADY,
  input  logic [1:0]                       BRESP
);

  localparam int unsigned MAX_BEATS = 2**LEN_W;
  localparam int unsigned CNT_W     = LEN_W + 1;
  localparam int unsigned BUF_W     = MAX_BEATS * DATA_W;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  // ---------------------------------------------------------------- read engine
  rd_state_t          rd_state, rd_state_d;
  logic [CNT_W-1:0]   rd_cnt, rd_cnt_d;
  logic [BUF_W-1:0]   rd_data_d;
  logic               rd_err_d;
  logic [ADDR_W-1:0]  ar_addr_d;
  logic [LEN_W-1:0]   ar_len_d;
  logic [ID_W-1:0]    ar_id_d;

  // Read next-state and datapath; the latched AR fields double as the burst length.
  always_comb begin
    rd_state_d = rd_state;
    rd_cnt_d   = rd_cnt;
    rd_data_d  = rd_data;
    rd_err_d   = rd_err;
    ar_addr_d  = ARADDR;
    ar_len_d   = ARLEN;
    ar_id_d    = ARID;
    case (rd_state)
      R_IDLE: begin
        if (rd_req) begin
          rd_state_d = R_ADDR;
          ar_addr_d  = rd_addr;
          ar_len_d   = rd_len;
          ar_id_d    = rd_id;
          rd_data_d  = '0;
          rd_err_d   = 1'b0;
          rd_cnt_d   = '0;
        end
      end
      R_ADDR: begin
        if (ARREADY) rd_state_d = R_DATA;
      end
      R_DATA: begin
        if (RVALID) begin
          // Beats beyond the requested length are dropped and flagged.
          if (rd_cnt <= {1'b0, ARLEN}) begin
            rd_data_d[rd_cnt[LEN_W-1:0]*DATA_W +: DATA_W] = RDATA;
          end else begin
            rd_err_d = 1'b1;
          end
          if (RRESP != 2'b00) rd_err_d = 1'b1;
          // Saturate rather than wrap so a runaway burst stays flagged.
          if (rd_cnt != {CNT_W{1'b1}}) rd_cnt_d = rd_cnt + CNT_W'(1);
          if (RLAST) begin
            if (rd_cnt != {1'b0, ARLEN}) rd_err_d = 1'b1;
            rd_state_d = R_IDLE;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= R_IDLE;
      rd_cnt   <= '0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
      rd_busy  <= 1'b0;
      rd_done  <= 1'b0;
      ARVALID  <= 1'b0;
      ARADDR   <= '0;
      ARLEN    <= '0;
      ARID     <= '0;
      RREADY   <= 1'b0;
    end else begin
      rd_state <= rd_state_d;
      rd_cnt   <= rd_cnt_d;
      rd_data  <= rd_data_d;
      rd_err   <= rd_err_d;
      rd_busy  <= (rd_state_d != R_IDLE);
      rd_done  <= (rd_state == R_DATA) && (rd_state_d == R_IDLE);
      ARVALID  <= (rd_state_d == R_ADDR);
      ARADDR   <= ar_addr_d;
      ARLEN    <= ar_len_d;
      ARID     <= ar_id_d;
      RREADY   <= (rd_state_d == R_DATA);
    end
  end

  // --------------------------------------------------------------- write engine
  wr_state_t          wr_state, wr_state_d;
  logic [CNT_W-1:0]   wr_cnt, wr_cnt_d;
  logic [BUF_W-1:0]   wbuf, wbuf_d;
  logic [ADDR_W-1:0]  aw_addr_d;
  logic [LEN_W-1:0]   aw_len_d;
  logic [ID_W-1:0]    aw_id_d;
  logic [1:0]         wr_resp_d;
  logic [DATA_W-1:0]  wdata_d;
  logic               wlast_d;

  // Write next-state and datapath; W payload is precomputed from the next count
  // so WDATA/WLAST are registered and valid in the same cycle as WVALID.
  always_comb begin
    wr_state_d = wr_state;
    wr_cnt_d   = wr_cnt;
    wbuf_d     = wbuf;
    aw_addr_d  = AWADDR;
    aw_len_d   = AWLEN;
    aw_id_d    = AWID;
    wr_resp_d  = wr_resp;
    wdata_d    = '0;
    wlast_d    = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (wr_req) begin
          wr_state_d = W_ADDR;
          aw_addr_d  = wr_addr;
          aw_len_d   = wr_len;
          aw_id_d    = wr_id;
          wbuf_d     = wr_data;
          wr_cnt_d   = '0;
        end
      end
      W_ADDR: begin
        if (AWREADY) wr_state_d = W_DATA;
      end
      W_DATA: begin
        if (WREADY) begin
          wr_cnt_d = wr_cnt + CNT_W'(1);
          if (wr_cnt == {1'b0, AWLEN}) wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BVALID) begin
          wr_resp_d  = BRESP;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    if (wr_state_d == W_DATA) begin
      wdata_d = wbuf_d[wr_cnt_d[LEN_W-1:0]*DATA_W +: DATA_W];
      wlast_d = (wr_cnt_d == {1'b0, aw_len_d});
    end
  end

  // Write state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= W_IDLE;
      wr_cnt   <= '0;
      wbuf     <= '0;
      wr_resp  <= 2'b00;
      wr_busy  <= 1'b0;
      wr_done  <= 1'b0;
      AWVALID  <= 1'b0;
      AWADDR   <= '0;
      AWLEN    <= '0;
      AWID     <= '0;
      WVALID   <= 1'b0;
      WDATA    <= '0;
      WLAST    <= 1'b0;
      BREADY   <= 1'b0;
    end else begin
      wr_state <= wr_state_d;
      wr_cnt   <= wr_cnt_d;
      wbuf     <= wbuf_d;
      wr_resp  <= wr_resp_d;
      wr_busy  <= (wr_state_d != W_IDLE);
      wr_done  <= (wr_state == W_RESP) && (wr_state_d == W_IDLE);
      AWVALID  <= (wr_state_d == W_ADDR);
      AWADDR   <= aw_addr_d;
      AWLEN    <= aw_len_d;
      AWID     <= aw_id_d;
      WVALID   <= (wr_state_d == W_DATA);
      WDATA    <= wdata_d;
      WLAST    <= wlast_d;
      BREADY   <= (wr_state_d == W_RESP);
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master: stimulus tasks push expected results,
// negedge monitors pop and compare when the DUT presents handshakes/done pulses.
module tb_axi_burst_master;

  localparam int unsigned BW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          rd_req = 1'b0;
  logic [7:0]    rd_addr = '0;
  logic [3:0]    rd_len = '0, rd_id = '0;
  logic          rd_busy, rd_done, rd_err;
  logic [BW-1:0] rd_data;
  logic          ARVALID, ARREADY = 1'b0;
  logic [7:0]    ARADDR;
  logic [3:0]    ARLEN, ARID;
  logic          RVALID = 1'b0, RREADY;
  logic [7:0]    RDATA = '0;
  logic [1:0]    RRESP = '0;
  logic          RLAST = 1'b0;
  logic          wr_req = 1'b0;
  logic [7:0]    wr_addr = '0;
  logic [3:0]    wr_len = '0, wr_id = '0;
  logic [BW-1:0] wr_data = '0;
  logic          wr_busy, wr_done;
  logic [1:0]    wr_resp;
  logic          AWVALID, AWREADY = 1'b0;
  logic [7:0]    AWADDR;
  logic [3:0]    AWLEN, AWID;
  logic          WVALID, WREADY = 1'b0;
  logic [7:0]    WDATA;
  logic          WLAST;
  logic          BVALID = 1'b0, BREADY;
  logic [1:0]    BRESP = '0;

  axi_burst_master dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_id(rd_id),
    .rd_busy(rd_busy), .rd_done(rd_done), .rd_err(rd_err), .rd_data(rd_data),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_id(wr_id), .wr_data(wr_data),
    .wr_busy(wr_busy), .wr_done(wr_done), .wr_resp(wr_resp),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  typedef struct packed {logic [BW-1:0] data; logic err;} rd_exp_t;
  typedef struct packed {logic [7:0] addr; logic [3:0] len; logic [3:0] id;} cmd_t;
  typedef struct packed {logic [7:0] d; logic last;} beat_t;

  rd_exp_t    q_rd[$];
  logic [1:0] q_wr[$];
  beat_t      q_w[$];
  cmd_t       q_ar[$];
  cmd_t       q_aw[$];

  int n_cmp = 0;
  int n_fail = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int unsigned rd_done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return RREADY;
      1: return WVALID;
      2: return BREADY;
      3: return !rd_busy;
      4: return !wr_busy;
      5: return ARVALID;
      6: return AWVALID;
      default: return 1'b0;
    endcase
  endfunction

  // Bounded wait, resuming #1 after a rising edge.
  task automatic wait_for(input int which, input string nm);
    int t = 0;
    while (!sig(which) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timed out after %0d cycles, required within 100", nm, t);
    end
  endtask

  function automatic logic any_out();
    return |{rd_busy, rd_done, rd_err, rd_data, ARVALID, ARADDR, ARLEN, ARID, RREADY,
             wr_busy, wr_done, wr_resp, AWVALID, AWADDR, AWLEN, AWID,
             WVALID, WDATA, WLAST, BREADY};
  endfunction

  // ------------------------------------------------------------------ monitors
  always @(negedge clk) begin : mon
    cmd_t e;
    rd_exp_t r;
    beat_t b;
    logic [1:0] wresp;
    if (rst) begin
      if (ARVALID && ARREADY) begin
        if (q_ar.size() == 0) check("ar_unexpected", 1, 0);
        else begin e = q_ar.pop_front(); check("ar_cmd", {ARADDR, ARLEN, ARID}, e); end
      end
      if (AWVALID && AWREADY) begin
        if (q_aw.size() == 0) check("aw_unexpected", 1, 0);
        else begin e = q_aw.pop_front(); check("aw_cmd", {AWADDR, AWLEN, AWID}, e); end
      end
      if (WVALID && WREADY) begin
        if (q_w.size() == 0) check("w_unexpected", 1, 0);
        else begin b = q_w.pop_front(); check("w_beat", {WDATA, WLAST}, b); end
      end
      if (rd_done) begin
        rd_done_cyc = cyc;
        if (q_rd.size() == 0) check("rd_done_unexpected", 1, 0);
        else begin
          r = q_rd.pop_front();
          check("rd_data", rd_data, r.data);
          check("rd_err", rd_err, r.err);
        end
      end
      if (wr_done) begin
        if (q_wr.size() == 0) check("wr_done_unexpected", 1, 0);
        else begin wresp = q_wr.pop_front(); check("wr_resp", wr_resp, wresp); end
      end
    end
  end

  // ------------------------------------------------------------ stimulus tasks
  task automatic rd_cmd(input logic [7:0] a, input logic [3:0] l, input logic [3:0] id,
                        input logic [BW-1:0] exp_data, input logic exp_err);
    rd_addr = a; rd_len = l; rd_id = id; rd_req = 1'b1;
    q_ar.push_back({a, l, id});
    q_rd.push_back({exp_data, exp_err});
  endtask

  task automatic wr_cmd(input logic [7:0] a, input logic [3:0] l, input logic [3:0] id,
                        input logic [BW-1:0] d, input logic [1:0] exp_resp, input logic exp_done);
    wr_addr = a; wr_len = l; wr_id = id; wr_data = d; wr_req = 1'b1;
    q_aw.push_back({a, l, id});
    for (int k = 0; k <= int'(l); k++) q_w.push_back({d[k*8 +: 8], k == int'(l)});
    if (exp_done) q_wr.push_back(exp_resp);
  endtask

  task automatic accept();
    logic r, w;
    r = rd_req; w = wr_req;
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
    acc_cyc = cyc;
    if (r) begin
      check("rd_busy_after_req", rd_busy, 1);
      check("arvalid_after_req", ARVALID, 1);
      check("rd_err_cleared", rd_err, 0);
    end
    if (w) begin
      check("wr_busy_after_req", wr_busy, 1);
      check("awvalid_after_req", AWVALID, 1);
      check("wvalid_before_aw", WVALID, 0);
    end
  endtask

  task automatic ar_slave(input int delay);
    wait_for(5, "arvalid");
    repeat (delay) begin
      check("arvalid_hold", ARVALID, 1);
      @(posedge clk); #1;
    end
    ARREADY = 1'b1;
    @(posedge clk); #1;
    ARREADY = 1'b0;
    check("rready_after_ar", RREADY, 1);
  endtask

  task automatic aw_slave(input int delay);
    wait_for(6, "awvalid");
    repeat (delay) begin
      check("awvalid_hold", AWVALID, 1);
      check("wvalid_low_in_aw", WVALID, 0);
      @(posedge clk); #1;
    end
    check("awvalid_at_hs", AWVALID, 1);
    check("wvalid_low_at_hs", WVALID, 0);
    AWREADY = 1'b1;
    @(posedge clk); #1;
    AWREADY = 1'b0;
    check("wvalid_after_aw", WVALID, 1);
  endtask

  task automatic r_slave(input logic [BW-1:0] d, input int last_beat, input int err_beat);
    for (int k = 0; k <= last_beat; k++) begin
      RVALID = 1'b1;
      RDATA  = d[k*8 +: 8];
      RRESP  = (k == err_beat) ? 2'b10 : 2'b00;
      RLAST  = (k == last_beat);
      wait_for(0, "rready");
      @(posedge clk); #1;
    end
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
  endtask

  task automatic w_slave(input int n, input int stall_beat, input int stall_cycles,
                         input logic [7:0] stall_exp);
    for (int k = 0; k < n; k++) begin
      if (k == stall_beat) begin
        WREADY = 1'b0;
        repeat (stall_cycles) begin
          check("wvalid_stall_hold", WVALID, 1);
          check("wdata_stall_hold", WDATA, stall_exp);
          check("wlast_stall_hold", WLAST, 0);
          @(posedge clk); #1;
        end
      end
      WREADY = 1'b1;
      wait_for(1, "wvalid");
      @(posedge clk); #1;
    end
    WREADY = 1'b0;
    check("wvalid_off_after_last", WVALID, 0);
    check("bready_after_last", BREADY, 1);
  endtask

  task automatic b_slave(input logic [1:0] resp);
    wait_for(2, "bready");
    BVALID = 1'b1; BRESP = resp;
    @(posedge clk); #1;
    BVALID = 1'b0; BRESP = 2'b00;
  endtask

  task automatic settle();
    wait_for(3, "rd_idle");
    wait_for(4, "wr_idle");
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------- tests
  initial begin
    logic [BW-1:0] rdv, wdv;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_zero", any_out(), 0);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Read len=3, no stalls
    rd_cmd(8'h40, 4'd3, 4'd5, BW'(32'h4433_2211), 1'b0);
    accept();
    ar_slave(0);
    r_slave(BW'(32'h4433_2211), 3, -1);
    settle();
    check("rd_done_latency", rd_done_cyc - acc_cyc, 5);

    // Write len=2, WREADY stalled two cycles on beat 1, BRESP=2
    wr_cmd(8'h80, 4'd2, 4'd3, BW'(24'hC3B2A1), 2'b10, 1'b1);
    accept();
    aw_slave(0);
    w_slave(3, 1, 2, 8'hB2);
    b_slave(2'b10);
    settle();

    // Read error: early RLAST on beat 1 of len=3
    rd_cmd(8'h10, 4'd3, 4'd1, BW'(16'h0201), 1'b1);
    accept();
    ar_slave(1);
    r_slave(BW'(32'h0403_0201), 1, -1);
    settle();

    // Read error: RRESP=2 on beat 0 (rd_err cleared again at acceptance)
    rd_cmd(8'h20, 4'd1, 4'd2, BW'(16'h6655), 1'b1);
    accept();
    ar_slave(0);
    r_slave(BW'(16'h6655), 1, 0);
    settle();

    // Concurrent len=15 read and write, AR/AW delayed 3; stray wr_req ignored
    for (int k = 0; k < 16; k++) begin
      rdv[k*8 +: 8] = 8'(k * 16 + 15 - k);
      wdv[k*8 +: 8] = 8'(8'h80 + k * 3);
    end
    rd_cmd(8'hA0, 4'd15, 4'd7, rdv, 1'b0);
    wr_cmd(8'hB0, 4'd15, 4'd8, wdv, 2'b01, 1'b1);
    accept();
    fork
      begin ar_slave(3); r_slave(rdv, 15, -1); end
      begin aw_slave(3); w_slave(16, -1, 0, 8'h00); b_slave(2'b01); end
      begin
        repeat (8) begin @(posedge clk); #1; end
        wr_addr = 8'hEE; wr_len = 4'd0; wr_data = '1; wr_req = 1'b1;
        @(posedge clk); #1;
        wr_req = 1'b0;
        check("stray_wr_req_ignored", AWVALID, 0);
      end
    join
    settle();

    // len=0 write, AWREADY held off 4 cycles
    wr_cmd(8'h33, 4'd0, 4'd9, BW'(8'h5A), 2'b00, 1'b1);
    accept();
    aw_slave(4);
    check("wlast_len0", WLAST, 1);
    w_slave(1, -1, 0, 8'h00);
    b_slave(2'b00);
    settle();

    // Reset during beat 2 of a len=5 write; restart from beat 0
    wr_cmd(8'h60, 4'd5, 4'd2, BW'(48'h1514_1312_1110), 2'b00, 1'b0);
    void'(q_w.pop_back()); void'(q_w.pop_back());
    void'(q_w.pop_back()); void'(q_w.pop_back());
    accept();
    aw_slave(0);
    WREADY = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    WREADY = 1'b0;
    check("wdata_beat2_before_reset", WDATA, 8'h12);
    #2 rst = 1'b0;
    #1 check("outputs_zero_midburst_reset", any_out(), 0);
    check("w_queue_drained", q_w.size(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    wr_cmd(8'h61, 4'd1, 4'd2, BW'(16'hD1D0), 2'b11, 1'b1);
    accept();
    aw_slave(0);
    check("restart_beat0", WDATA, 8'hD0);
    w_slave(2, -1, 0, 8'h00);
    b_slave(2'b11);
    settle();

    check("q_rd_empty", q_rd.size(), 0);
    check("q_wr_empty", q_wr.size(), 0);
    check("q_w_empty", q_w.size(), 0);
    check("q_ar_empty", q_ar.size(), 0);
    check("q_aw_empty", q_aw.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
